// File: rtl/mp_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states, instruction width helper.
// Latency: none, compile-time constants only.
// Backpressure: none, no datapath of its own.
package mp_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_WB    = 2'd3
  } state_t;

  // Two opcode bits followed by three register-sized fields (rs, rt, rd/imm).
  function automatic int instr_width(input int reg_aw);
    return 2 + 3 * reg_aw;
  endfunction

endpackage

// File: rtl/reg_file_param.sv
// Register file: 2 asynchronous read ports, 1 synchronous write port, no hardwired zero.
// Latency: reads combinational, write visible the cycle after the write edge.
// Backpressure: none; a write is taken whenever we is high and reset is released.
module reg_file_param
  import mp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] regs [NREG];

  // Clear wins over a coincident write so a reset cancels an in-flight write-back.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/multicycle_microprocessor.sv
// Multi-cycle four-opcode core (ADD/LW/SW/BEQ) with fetch handshake and write-back observation port.
// Latency from fetch accept to next request: ADD 3, LW 4, SW 3, BEQ 2 cycles; wb_valid at +2 (ADD) / +3 (LW).
// Backpressure: only the fetch stalls (waits in FETCH until instr_valid); every other state takes one cycle.
module multicycle_microprocessor
  import mp_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int REG_AW  = 2,
  parameter  int DMEM_AW = 5,
  parameter  int PC_W    = 8,
  localparam int INSTR_W = instr_width(REG_AW)
) (
  input  logic               CLK,
  input  logic               reset,
  output logic               instr_req,
  output logic [PC_W-1:0]    instr_addr,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               wb_valid,
  output logic [REG_AW-1:0]  wb_reg,
  output logic [DATA_W-1:0]  wb_data
);

  localparam int DMEM_N = 1 << DMEM_AW;

  state_t             state;
  state_t             state_nxt;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] ir;
  logic               run;
  logic [DATA_W-1:0]  res_q;
  logic [DATA_W-1:0]  st_q;
  logic [DMEM_AW-1:0] addr_q;
  logic [REG_AW-1:0]  dst_q;
  logic [DATA_W-1:0]  dmem [DMEM_N];

  // Instruction fields, always taken from the latched IR.
  logic [1:0]         op;
  logic [REG_AW-1:0]  rs;
  logic [REG_AW-1:0]  rt;
  logic [REG_AW-1:0]  rd_imm;

  assign op     = ir[INSTR_W-1 -: 2];
  assign rs     = ir[3*REG_AW-1 -: REG_AW];
  assign rt     = ir[2*REG_AW-1 -: REG_AW];
  assign rd_imm = ir[REG_AW-1:0];

  logic [DATA_W-1:0]  rs_val;
  logic [DATA_W-1:0]  rt_val;
  logic               rf_we;

  // Write happens on the edge that leaves WB.
  assign rf_we = (state == S_WB);

  reg_file_param #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_reg_file (
    .CLK     (CLK),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (dst_q),
    .wdata   (res_q),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rs_val),
    .rdata_b (rt_val)
  );

  // Sign-extended immediate in the two address spaces that use it.
  logic [DMEM_AW-1:0] imm_dm;
  logic [PC_W-1:0]    imm_pc;
  logic [DMEM_AW-1:0] ea;
  logic [PC_W-1:0]    pc_inc;
  logic               take_br;

  assign imm_dm  = DMEM_AW'($signed(rd_imm));
  assign imm_pc  = PC_W'($signed(rd_imm));
  // Only the low DMEM_AW bits of rs matter for an address taken modulo the memory depth.
  assign ea      = DMEM_AW'(rs_val) + imm_dm;
  assign pc_inc  = pc + PC_W'(1);
  assign take_br = (op == OP_BEQ) && (rs_val == rt_val);

  // run holds instr_req low for the first cycle after reset is released.
  logic fetch_acc;

  assign instr_req  = run && (state == S_FETCH);
  assign instr_addr = pc;
  assign fetch_acc  = instr_req && instr_valid;

  assign wb_valid = (state == S_WB);
  assign wb_reg   = wb_valid ? dst_q : '0;
  assign wb_data  = wb_valid ? res_q : '0;

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: fetch waits for the handshake, every other state advances unconditionally.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_FETCH: begin
        if (fetch_acc) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op == OP_ADD) begin
          state_nxt = S_WB;
        end else if ((op == OP_LW) || (op == OP_SW)) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        state_nxt = (op == OP_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // Datapath: IR capture, ALU/address latch and PC update in EXEC, load capture in MEM.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      run    <= 1'b0;
      pc     <= '0;
      ir     <= '0;
      res_q  <= '0;
      st_q   <= '0;
      addr_q <= '0;
      dst_q  <= '0;
    end else begin
      run <= 1'b1;
      unique case (state)
        S_FETCH: begin
          if (fetch_acc) begin
            ir <= instr;
          end
        end
        S_EXEC: begin
          pc     <= take_br ? (pc_inc + imm_pc) : pc_inc;
          addr_q <= ea;
          st_q   <= rt_val;
          if (op == OP_ADD) begin
            res_q <= rs_val + rt_val;
            dst_q <= rd_imm;
          end else begin
            dst_q <= rt;
          end
        end
        S_MEM: begin
          if (op == OP_LW) begin
            res_q <= dmem[addr_q];
          end
        end
        S_WB: begin
        end
      endcase
    end
  end

  // Data memory: resets to an identity pattern; a store commits only on the edge leaving MEM.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      for (int i = 0; i < DMEM_N; i++) begin
        dmem[i] <= DATA_W'(i);
      end
    end else if ((state == S_MEM) && (op == OP_SW)) begin
      dmem[addr_q] <= st_q;
    end
  end

endmodule

// File: tb/tb_multicycle_microprocessor.sv
// Bench for multicycle_microprocessor: directed programs then random programs against an ISA-level model.
// Expected write-backs and fetches are queued at issue time and checked by an independent monitor.
// The bench acts as a zero- or multi-wait instruction memory.
module tb_multicycle_microprocessor;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       instr_req;
  logic [7:0] instr_addr;
  logic       instr_valid = 1'b0;
  logic [7:0] instr = 8'h00;
  logic       wb_valid;
  logic [1:0] wb_reg;
  logic [7:0] wb_data;

  multicycle_microprocessor dut (
    .CLK         (CLK),
    .reset       (reset),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr       (instr),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .wb_data     (wb_data)
  );

  always #5 CLK = ~CLK;

  typedef struct { int r; int d; int c; } wb_exp_t;
  typedef struct { int a; int c; } fe_exp_t;

  wb_exp_t wb_q[$];
  fe_exp_t fe_q[$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic rst_s = 1'b0;
  logic rst_d = 1'b0;
  logic prev_req = 1'b0;
  int   cur_addr = 0;

  // ISA-level model state.
  int m_reg[4];
  int m_mem[32];
  int m_pc;

  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    rst_s <= reset;
    rst_d <= rst_s;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 2) ? v - 4 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = i;
    m_pc = 0;
    wb_q.delete();
    fe_q.delete();
  endtask

  // Apply one instruction to the model; a = cycle index of the EXEC cycle.
  task automatic model_exec(input logic [7:0] ins);
    int op, rs, rt, im, a, lat, ea;
    op  = int'(ins[7:6]);
    rs  = int'(ins[5:4]);
    rt  = int'(ins[3:2]);
    im  = int'(ins[1:0]);
    a   = cyc;
    lat = 3;
    ea  = (m_reg[rs] + sx(im)) & 31;
    case (op)
      0: begin
        m_reg[im] = (m_reg[rs] + m_reg[rt]) & 255;
        wb_q.push_back('{im, m_reg[im], a + 1});
      end
      1: begin
        m_reg[rt] = m_mem[ea];
        wb_q.push_back('{rt, m_reg[rt], a + 2});
        lat = 4;
      end
      2: m_mem[ea] = m_reg[rt];
      default: begin
        lat = 2;
        if (m_reg[rs] == m_reg[rt]) m_pc = (m_pc + sx(im)) & 255;
      end
    endcase
    m_pc = (m_pc + 1) & 255;
    fe_q.push_back('{m_pc, a + lat - 1});
  endtask

  // Serve one fetch after 'waits' stall cycles, then leave garbage on the bus while no request is open.
  task automatic issue(input logic [7:0] ins, input int waits);
    int t;
    t = 0;
    @(negedge CLK);
    while (!instr_req && t < 64) begin
      @(negedge CLK);
      t++;
    end
    if (!instr_req) begin
      chk("fetch_timeout", {63'd0, instr_req}, 64'd1);
      return;
    end
    instr_valid = 1'b0;
    repeat (waits) @(negedge CLK);
    instr_valid = 1'b1;
    instr = ins;
    @(posedge CLK);
    #1;
    model_exec(ins);
    instr_valid = 1'($urandom_range(0, 1));
    instr = 8'($urandom);
  endtask

  task automatic do_reset(input int n);
    instr_valid = 1'b0;
    reset = 1'b0;
    @(posedge CLK);
    #1;
    model_reset();
    repeat (n - 1) @(posedge CLK);
    #1 reset = 1'b1;
    fe_q.push_back('{0, -1});
  endtask

  // Monitor: compares every DUT-presented event against the queued expectations.
  always @(negedge CLK) begin
    if (!rst_s) begin
      chk("reset_outputs", {45'd0, wb_valid, wb_reg, wb_data, instr_req, instr_addr}, 64'd0);
      prev_req = 1'b0;
    end else begin
      if (!rst_d) chk("req_after_reset", {63'd0, instr_req}, 64'd1);
      if (wb_valid) begin
        if (wb_q.size() == 0) begin
          chk("unexpected_wb", {63'd0, wb_valid}, 64'd0);
        end else begin
          wb_exp_t e;
          e = wb_q.pop_front();
          chk("wb_reg", 64'(wb_reg), 64'(e.r));
          chk("wb_data", 64'(wb_data), 64'(e.d));
          chk("wb_cycle", 64'(cyc), 64'(e.c));
        end
      end
      if (instr_req && !prev_req) begin
        if (fe_q.size() == 0) begin
          chk("unexpected_fetch", {63'd0, instr_req}, 64'd0);
        end else begin
          fe_exp_t f;
          f = fe_q.pop_front();
          cur_addr = f.a;
          chk("fetch_addr", 64'(instr_addr), 64'(f.a));
          if (f.c >= 0) chk("fetch_cycle", 64'(cyc), 64'(f.c));
        end
      end else if (instr_req) begin
        chk("addr_stable", 64'(instr_addr), 64'(cur_addr));
      end
      prev_req = instr_req;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    model_reset();
    // Reset, then hold off the fetch for several cycles.
    do_reset(3);
    instr_valid = 1'b0;
    repeat (4) @(negedge CLK);

    // Loads, wraparound address, add, store and reload.
    issue(8'h45, 0);
    issue(8'h47, 1);
    issue(8'h45, 0);
    issue(8'h16, 2);
    issue(8'h89, 0);
    issue(8'h4D, 3);

    // Branches: backward from PC 0 wraps to 0xFF, forward from 0xFF wraps to 0x01,
    // taken and not-taken from PC 5.
    do_reset(2);
    issue(8'hC2, 0);
    issue(8'hC1, 0);
    issue(8'h45, 0);
    issue(8'h00, 0);
    issue(8'h00, 1);
    issue(8'h00, 0);
    issue(8'hC2, 0);
    issue(8'h00, 0);
    issue(8'hDA, 0);
    issue(8'h00, 0);

    // Random programs with random fetch wait states.
    for (int i = 0; i < 250; i++) begin
      issue(8'($urandom), $urandom_range(0, 3));
    end

    // Reset during the MEM cycle of a store: the store must not land.
    do_reset(2);
    issue(8'h45, 0);
    issue(8'h16, 0);
    issue(8'h89, 0);
    @(posedge CLK);
    #1;
    do_reset(2);
    issue(8'h45, 0);
    issue(8'h16, 1);

    instr_valid = 1'b0;
    repeat (8) @(negedge CLK);
    chk("wb_pending", 64'(wb_q.size()), 64'd0);
    chk("fetch_pending", 64'(fe_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
